// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: one outstanding miss, memory read over valid/ready, single-word fill.
// Optional WAIT-state timeout with fill_err is enabled by defining ICACHE_REFILL_TIMEOUT_EN.
module icache_refill_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                miss_valid,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                miss_ready,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                fill_we,
  output logic [INDEX_W-1:0]  fill_index,
  output logic [ADDR_W-3:0]   fill_tag,
  output logic [DATA_W-1:0]   fill_data,
  output logic                fill_done,
  output logic                fill_err,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } stateT;

  stateT             stateReg;
  stateT             stateNext;
  logic [ADDR_W-3:0] blockAddrReg;
  logic [DATA_W-1:0] dataReg;
  logic              timeoutHit;
  logic              unusedBits;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= IDLE;
      blockAddrReg <= '0;
      dataReg      <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == IDLE && miss_valid)
        blockAddrReg <= miss_addr[ADDR_W-1:2];
      // Responses are only captured in WAIT; anything earlier is a stray beat.
      if (stateReg == WAIT && mem_resp_valid)
        dataReg <= mem_resp_data;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (miss_valid) stateNext = REQ;
      REQ:     if (mem_req_ready) stateNext = WAIT;
      WAIT: begin
        if (mem_resp_valid)  stateNext = WRITE;
        else if (timeoutHit) stateNext = IDLE;
      end
      WRITE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign miss_ready    = (stateReg == IDLE);
  assign busy          = (stateReg != IDLE);
  assign mem_req_valid = (stateReg == REQ);
  assign mem_req_addr  = {blockAddrReg, 2'b00};
  assign fill_we       = (stateReg == WRITE);
  assign fill_done     = (stateReg == WRITE);
  assign fill_index    = blockAddrReg[INDEX_W-1:0];
  assign fill_tag      = blockAddrReg;
  assign fill_data     = dataReg;

`ifdef ICACHE_REFILL_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] waitCntReg;
  logic             errReg;

  // Limit is reached on the edge that would bring the count to TIMEOUT; a response that cycle wins.
  assign timeoutHit = (stateReg == WAIT) && !mem_resp_valid &&
                      (waitCntReg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      waitCntReg <= '0;
      errReg     <= 1'b0;
    end else begin
      errReg <= timeoutHit;
      if (stateReg != WAIT)
        waitCntReg <= '0;
      else if (!mem_resp_valid)
        waitCntReg <= waitCntReg + CNT_W'(1);
    end
  end

  assign fill_err   = errReg;
  assign unusedBits = ^miss_addr[1:0];
`else
  assign timeoutHit = 1'b0;
  assign fill_err   = 1'b0;
  assign unusedBits = ^{miss_addr[1:0], (TIMEOUT != 0)};
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a fill-queue model plus per-cycle protocol checks and literal timing checks.
// Timeout scenario depends on ICACHE_REFILL_TIMEOUT_EN at compile time.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        fill_we;
  logic [3:0]  fill_index;
  logic [29:0] fill_tag;
  logic [31:0] fill_data;
  logic        fill_done;
  logic        fill_err;
  logic        busy;

  icache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEX_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag), .fill_data(fill_data),
    .fill_done(fill_done), .fill_err(fill_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic [29:0] tag;
    logic [31:0] data;
  } fillT;

  fillT        expQ[$];
  logic [31:0] expReqAddr = '0;
  int          checks = 0;
  int          passes = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a miss on byte address A fills set (A>>2)%16 with tag A>>2 and the accepted response word.
  task automatic pushFill(input logic [31:0] addr, input logic [31:0] data);
    fillT f;
    f.idx  = addr[5:2];
    f.tag  = addr[31:2];
    f.data = data;
    expQ.push_back(f);
  endtask

  task automatic startMiss(input logic [31:0] addr);
    miss_valid = 1'b1;
    miss_addr  = addr;
    expReqAddr = {addr[31:2], 2'b00};
    tick();
    miss_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] addr, input logic [31:0] data);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    pushFill(addr, data);
    tick();
    mem_resp_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("busyVsMissReady", busy, !miss_ready);
      check("doneVsWe", fill_done, fill_we);
      if (mem_req_valid) check("reqAddr", mem_req_addr, expReqAddr);
`ifndef ICACHE_REFILL_TIMEOUT_EN
      check("errTiedLow", fill_err, 1'b0);
`endif
      if (fill_we) begin
        $display("fill idx=%0d tag=0x%0h data=0x%08h", fill_index, fill_tag, fill_data);
        if (expQ.size() == 0) begin
          check("fillExpected", 1'b0, 1'b1);
        end else begin
          fillT f;
          f = expQ.pop_front();
          check("fillIndex", fill_index, f.idx);
          check("fillTag", fill_tag, f.tag);
          check("fillData", fill_data, f.data);
        end
      end
    end
  end

  initial begin
    // 1: reset and idle
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("rstMissReady", miss_ready, 1'b1);
      check("rstBusy", busy, 1'b0);
      check("rstStrobes", {mem_req_valid, fill_we, fill_done, fill_err}, 4'b0);
      check("rstRegs", {mem_req_addr, fill_index, fill_tag, fill_data}, '0);
      tick();
    end

    // 2: basic fill, then back-to-back miss to the same index
    mem_req_ready = 1'b1;
    startMiss(32'h0000_0104);
    check("t2ReqValid", mem_req_valid, 1'b1);
    check("t2ReqAddr", mem_req_addr, 32'h0000_0104);
    tick();
    check("t2WaitNoReq", {busy, mem_req_valid}, 2'b10);
    respond(32'h0000_0104, 32'h8B01_0022);
    check("t2WeCycle3", {fill_we, fill_done}, 2'b11);
    check("t2Index", fill_index, 4'd1);
    check("t2Tag", fill_tag, 30'h41);
    check("t2Data", fill_data, 32'h8B01_0022);
    tick();
    check("t2IdleCycle4", {miss_ready, busy, fill_we}, 3'b100);
    startMiss(32'h0000_0504);
    check("t2BackToBack", mem_req_valid, 1'b1);
    tick();
    respond(32'h0000_0504, 32'h0BAD_F00D);
    check("t2OverwriteIdx", fill_index, 4'd1);
    check("t2OverwriteTag", fill_tag, 30'h141);
    tick();

    // 3: request stall with a second miss pulse while busy
    mem_req_ready = 1'b0;
    startMiss(32'h0000_0128);
    for (int i = 0; i < 5; i++) begin
      check("t3ReqHeld", mem_req_valid, 1'b1);
      check("t3AddrStable", mem_req_addr, 32'h0000_0128);
      check("t3NoAccept", miss_ready, 1'b0);
      if (i == 1) begin miss_valid = 1'b1; miss_addr = 32'h0000_0200; end
      if (i == 2) miss_valid = 1'b0;
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    respond(32'h0000_0128, 32'h600D_CAFE);
    check("t3We", fill_we, 1'b1);
    check("t3Index", fill_index, 4'd10);
    check("t3Tag", fill_tag, 30'h4A);
    tick();

    // 4: stray responses in REQ, including the handshake cycle
    startMiss(32'h0000_03FC);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    check("t4InWait", {busy, fill_we}, 2'b10);
    tick();
    respond(32'h0000_03FC, 32'h17FF_FFFA);
    check("t4Data", fill_data, 32'h17FF_FFFA);
    tick();

    // 5: reset during WAIT, response right after
    mem_req_ready = 1'b1;
    startMiss(32'h0000_0040);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      check("t5NoFill", fill_we, 1'b0);
      check("t5Idle", {miss_ready, busy}, 2'b10);
      check("t5TagCleared", fill_tag, 30'h0);
      tick();
      mem_resp_valid = 1'b0;
    end

    // 6: timeout behaviour
    startMiss(32'h0000_0080);
    tick();
    mem_req_ready = 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      check("t6Waiting", {busy, fill_err}, 2'b10);
      tick();
    end
    check("t6LastWait", {busy, fill_err}, 2'b10);
    tick();
    check("t6ErrPulse", {fill_err, fill_we, busy, miss_ready}, 4'b1001);
    tick();
    check("t6ErrDone", fill_err, 1'b0);
    mem_req_ready = 1'b1;
    startMiss(32'h0000_0084);
    tick();
    for (int i = 1; i < 8; i++) tick();
    respond(32'h0000_0084, 32'hC0DE_0001);
    check("t6RespWins", {fill_we, fill_err}, 2'b10);
    tick();
    check("t6NoLateErr", fill_err, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      check("t6HoldBusy", {busy, fill_err, fill_we}, 3'b100);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6Recovered", miss_ready, 1'b1);
`endif
    tick();
    check("allFillsSeen", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
